// File: rtl/mult_pkg.sv
// rtl/mult_pkg.sv - shared types for the sequential multiplier
// Purpose: FSM state encoding used by seq_mult_mnbit.
// Ports: none (package).
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX,
    DONE
  } state_t;

endpackage

// File: rtl/rca_nbit.sv
// rtl/rca_nbit.sv - W-bit ripple-carry adder
// Purpose: combinational adder used for the per-step partial-product add.
// Ports:
//   a, b : W-bit addends
//   cin  : carry in
//   sum  : W-bit sum
//   cout : carry out of the top bit
module rca_nbit #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar i = 0; i < W; i++) begin : g_fa
    assign sum[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i + 1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end

  assign cout = c[W];

endmodule

// File: rtl/seq_mult_mnbit.sv
// rtl/seq_mult_mnbit.sv - radix-2 sequential signed/unsigned multiplier
// Purpose: multiplies an M-bit a by an N-bit b in N shift-add steps,
//          sign handled by magnitude multiply plus a final negate.
// Ports:
//   clk   : clock, rising edge
//   rst   : synchronous active-high reset
//   start : begin a multiplication (accepted in IDLE or DONE)
//   sgn   : 1 = two's-complement operands, 0 = unsigned
//   a     : M-bit multiplicand
//   b     : N-bit multiplier
//   prod  : (M+N)-bit registered result
//   busy  : high in CALC and FIX
//   done  : one-cycle pulse when prod is valid
module seq_mult_mnbit
  import mult_pkg::*;
#(
  parameter int M = 4,
  parameter int N = 4
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic           sgn,
  input  logic [M-1:0]   a,
  input  logic [N-1:0]   b,
  output logic [M+N-1:0] prod,
  output logic           busy,
  output logic           done
);

  localparam int CW = $clog2(N + 1);
  localparam int PW = M + N + 1;

  state_t        state;
  logic [M-1:0]  mcand;
  logic [PW-1:0] pp;
  logic          neg;
  logic [CW-1:0] cnt;

  logic [M-1:0]  a_abs;
  logic [N-1:0]  b_abs;
  logic [M-1:0]  add_sum;
  logic          add_cout;
  logic [PW-1:0] pp_step;

  // Negating the most-negative value wraps to itself, which read as
  // unsigned is exactly its magnitude.
  assign a_abs = (sgn && a[M-1]) ? -a : a;
  assign b_abs = (sgn && b[N-1]) ? -b : b;

  rca_nbit #(.W(M)) u_add (
    .a    (pp[PW-2:N]),
    .b    (mcand),
    .cin  (1'b0),
    .sum  (add_sum),
    .cout (add_cout)
  );

  // Multiplier bits sit in the low N bits and drain out as the product
  // shifts in from the top; the carry lands in the spare top bit.
  assign pp_step = pp[0] ? {add_cout, add_sum, pp[N-1:0]} : pp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      prod  <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      mcand <= '0;
      pp    <= '0;
      neg   <= 1'b0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          done <= 1'b0;
          if (start) begin
            mcand <= a_abs;
            pp    <= {{(M + 1){1'b0}}, b_abs};
            neg   <= sgn & (a[M-1] ^ b[N-1]);
            cnt   <= '0;
            busy  <= 1'b1;
            state <= CALC;
          end else begin
            state <= IDLE;
          end
        end
        CALC: begin
          pp  <= pp_step >> 1;
          cnt <= cnt + CW'(1);
          if (cnt == CW'(N - 1)) begin
            state <= FIX;
          end
        end
        FIX: begin
          // A zero magnitude negates to zero, so no negative zero appears.
          prod  <= neg ? -pp[PW-2:0] : pp[PW-2:0];
          busy  <= 1'b0;
          done  <= 1'b1;
          state <= DONE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_mult_mnbit.sv
// tb/tb_seq_mult_mnbit.sv - scoreboard bench for seq_mult_mnbit
module tb_seq_mult_mnbit;

  typedef struct {
    logic       s;
    logic [3:0] x;
    logic [3:0] y;
    logic [7:0] e;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, start, sgn;
  logic [3:0] a, b;
  logic [7:0] prod;
  logic       busy, done;

  logic       start2, sgn2;
  logic [5:0] a2;
  logic [2:0] b2;
  logic [8:0] prod2;
  logic       busy2, done2;

  int          checks = 0;
  int          errors = 0;
  int          ndone1 = 0;
  int          npush1 = 0;
  logic [31:0] q1[$];
  logic [31:0] q2[$];
  logic [7:0]  held;
  vec_t        tbl[0:8];

  seq_mult_mnbit #(.M(4), .N(4)) dut (
    .clk(clk), .rst(rst), .start(start), .sgn(sgn), .a(a), .b(b),
    .prod(prod), .busy(busy), .done(done)
  );

  seq_mult_mnbit #(.M(6), .N(3)) dut63 (
    .clk(clk), .rst(rst), .start(start2), .sgn(sgn2), .a(a2), .b(b2),
    .prod(prod2), .busy(busy2), .done(done2)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      ndone1++;
      if (q1.size() == 0) check("unexpected_done", 32'(done), 32'd0);
      else check("prod", 32'(prod), q1.pop_front());
    end
    if (busy === 1'b1) check("prod_hold", 32'(prod), 32'(held));
    else held <= prod;
    if (done2 === 1'b1) begin
      if (q2.size() == 0) check("unexpected_done2", 32'(done2), 32'd0);
      else check("prod2", 32'(prod2), q2.pop_front());
    end
  end

  task automatic launch(input logic s, input logic [3:0] x, input logic [3:0] y,
                        input logic [7:0] e, input bit push);
    sgn   = s;
    a     = x;
    b     = y;
    start = 1'b1;
    if (push) begin
      q1.push_back(32'(e));
      npush1++;
    end
  endtask

  // Called at the negedge where start was raised; the next posedge accepts.
  task automatic await_done(input string tag, input int poke_at);
    int lat;
    int bc;
    bit got;
    lat = 0;
    bc  = 0;
    got = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    if (busy) bc++;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (lat == poke_at) begin
        start = 1'b1;
        a     = 4'd1;
        b     = 4'd1;
      end else if (lat == poke_at + 1) begin
        start = 1'b0;
      end
      if (done) got = 1'b1;
      else if (busy) bc++;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd5);
    check({tag, "_busy_cycles"}, 32'(bc), 32'd5);
  endtask

  task automatic run2(input logic s, input logic [5:0] x, input logic [2:0] y,
                      input logic [8:0] e);
    int lat;
    bit got;
    lat    = 0;
    got    = 1'b0;
    sgn2   = s;
    a2     = x;
    b2     = y;
    start2 = 1'b1;
    q2.push_back(32'(e));
    @(posedge clk);
    @(negedge clk);
    start2 = 1'b0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (done2) got = 1'b1;
    end
    check("m6n3_done_seen", 32'(got), 32'd1);
    check("m6n3_latency", 32'(lat), 32'd4);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; sgn = 1'b0; a = '0; b = '0;
    start2 = 1'b0; sgn2 = 1'b0; a2 = '0; b2 = '0;

    tbl[0] = '{1'b1, 4'h8, 4'h8, 8'h40};
    tbl[1] = '{1'b1, 4'hD, 4'h5, 8'hF1};
    tbl[2] = '{1'b1, 4'h0, 4'h9, 8'h00};
    tbl[3] = '{1'b0, 4'h0, 4'hF, 8'h00};
    tbl[4] = '{1'b1, 4'h7, 4'h8, 8'hC8};
    tbl[5] = '{1'b1, 4'hF, 4'hF, 8'h01};
    tbl[6] = '{1'b0, 4'hC, 4'hB, 8'h84};
    tbl[7] = '{1'b1, 4'h8, 4'h7, 8'hC8};
    tbl[8] = '{1'b1, 4'hF, 4'h1, 8'hFF};

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_prod", 32'(prod), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_prod2", 32'(prod2), 32'd0);
    check("rst_busy2", 32'(busy2), 32'd0);
    rst = 1'b0;

    launch(1'b0, 4'd15, 4'd15, 8'd225, 1'b1);
    await_done("u15x15", -5);

    for (int k = 0; k < 9; k++) begin
      @(negedge clk);
      check("idle_busy", 32'(busy), 32'd0);
      check("done_one_cycle", 32'(done), 32'd0);
      launch(tbl[k].s, tbl[k].x, tbl[k].y, tbl[k].e, 1'b1);
      await_done("table", -5);
    end

    @(negedge clk);
    launch(1'b0, 4'd7, 4'd8, 8'd56, 1'b1);
    await_done("pre_b2b", -5);
    launch(1'b0, 4'd2, 4'd3, 8'd6, 1'b1);
    await_done("b2b", -5);

    @(negedge clk);
    launch(1'b0, 4'd7, 4'd9, 8'd63, 1'b1);
    await_done("ignore_start", 1);
    repeat (3) @(negedge clk);
    check("ignore_idle_busy", 32'(busy), 32'd0);

    rst = 1'b1;
    launch(1'b0, 4'd5, 4'd5, 8'd25, 1'b0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    start = 1'b0;
    check("rst_prio_busy", 32'(busy), 32'd0);
    check("rst_prio_prod", 32'(prod), 32'd0);
    @(negedge clk);
    check("rst_prio_stay_idle", 32'(busy), 32'd0);

    launch(1'b0, 4'd3, 4'd3, 8'd9, 1'b1);
    await_done("pre_abort", -5);
    @(negedge clk);
    launch(1'b0, 4'd15, 4'd15, 8'd225, 1'b0);
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    check("abort_busy_before", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_prod", 32'(prod), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    repeat (8) @(negedge clk);
    check("abort_still_idle", 32'(busy), 32'd0);

    run2(1'b0, 6'd63, 3'd7, 9'd441);
    run2(1'b1, 6'h20, 3'h4, 9'h080);
    run2(1'b1, 6'h20, 3'h3, 9'h1A0);
    run2(1'b1, 6'h3F, 3'h4, 9'h004);

    repeat (3) @(negedge clk);
    check("done_count", 32'(ndone1), 32'(npush1));
    check("queues_drained", 32'(q1.size() + q2.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_mult_mnbit.md
SEQ_MULT_MNBIT -- requirements
Module: seq_mult_mnbit

Interface
REQ-001 SHALL have parameter M, default 4: width of operand a; legal range 2..32.
REQ-002 SHALL have parameter N, default 4: width of operand b and iteration count; legal range 2..32.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1: request to begin a multiplication.
REQ-006 SHALL have port sgn, input, 1: 1 means operands are two's complement, 0 means unsigned.
REQ-007 SHALL have port a, input, M: multiplicand.
REQ-008 SHALL have port b, input, N: multiplier.
REQ-009 SHALL have port prod, output, M+N: registered result.
REQ-010 SHALL have port busy, output, 1: high while a multiplication is in progress.
REQ-011 SHALL have port done, output, 1: one-cycle pulse marking prod valid.

Function
REQ-012 SHALL implement FSM states IDLE, CALC, FIX, DONE.
REQ-013 SHALL accept start only in IDLE or DONE, sampling a, b and sgn on that edge and entering CALC.
- Accepting start in DONE gives back-to-back operation.
REQ-014 SHALL ignore start in CALC and FIX, with no effect on the operation in progress.
REQ-015 SHALL capture |a| and |b| at acceptance when sgn=1, plus a result-negate flag equal to a[M-1] XOR b[N-1].
- When sgn=0, both operands are used as-is and the negate flag is 0.
REQ-016 SHALL handle the most-negative operand (-2^(M-1) or -2^(N-1)) correctly; its magnitude fits the unsigned M-bit or N-bit register.
REQ-017 SHALL perform one radix-2 shift-add step per edge in CALC.
- If the multiplier LSB is 1: add the multiplicand to the upper M bits of a partial-product register of width M+N+1.
- Then shift the register right by one.
REQ-018 SHALL hold an iteration counter of width clog2(N+1), cleared on acceptance, and leave CALC for FIX after exactly N steps.
REQ-019 SHALL, in FIX, load prod with the two's-complement negation of the magnitude product if the negate flag is set, else with the product itself, and go to DONE.
REQ-020 SHALL assert done for exactly the one cycle spent in DONE.
- done appears N+1 edges after the accepting edge.
REQ-021 SHALL go from DONE to IDLE unless start is sampled high in DONE.
REQ-022 SHALL drive busy high exactly in CALC and FIX.
REQ-023 SHALL hold prod stable from DONE until the next FIX load; it SHALL NOT change during CALC.
REQ-024 SHALL produce exact results for all operands: the unsigned range 0..(2^M-1)(2^N-1) and the full signed range, with no overflow.
REQ-025 SHALL yield prod=0 for a zero operand in either mode, with no negative zero.

Reset
REQ-026 SHALL, when rst is sampled high, enter IDLE and clear prod, busy, done, the counter and all datapath registers.
REQ-027 SHALL let rst take priority over start on the same edge.
REQ-028 SHALL abort an operation on rst mid-CALC or mid-FIX: no done pulse, prod=0.

Structure
REQ-029 SHALL take the FSM state enum type (state_t: IDLE, CALC, FIX, DONE) from a shared package mult_pkg.
REQ-030 SHALL instantiate exactly one rca_nbit of width M for the per-step add; its carry-out feeds bit M of the partial-product upper field.
REQ-031 SHALL keep the remaining datapath (magnitude, negate, shift, counter) inside seq_mult_mnbit, with no further sub-modules.

Verification (M=N=4 unless stated)
REQ-032 SHALL be verified for unsigned a=15, b=15, start in IDLE: expect busy for 5 cycles, then done one cycle with prod=0xE1 (225).
REQ-033 SHALL be verified for signed a=-8, b=-8: expect prod=0x40. Also signed a=-3, b=5: expect prod=0xF1 (-15).
REQ-034 SHALL be verified for signed a=0, b=-7: expect prod=0x00.
REQ-035 SHALL be verified by asserting start in the DONE cycle with a=2, b=3 unsigned: the next done shows prod=6 with no IDLE cycle in between.
REQ-036 SHALL be verified by start pulsed with a=1, b=1 during CALC of a 7*9 operation: expect it ignored, prod=63, one done only.
REQ-037 SHALL be verified by rst asserted on the 2nd CALC edge: next cycle IDLE, busy=0, prod=0, no done. Then an M=6, N=3 build with unsigned a=63, b=7 gives prod=441.
